mem_port_arbiter: RTL

//  Shares the single-ported unified memory between instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/load-store request bundle plus memory command bus for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;
    logic              busy;
    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        output i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_wr, mem_addr, mem_wdata, busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), D first.
// Define ARB_STARVE_GUARD_EN to force an I grant after STARVE_MAX D grants made while I waits.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 2 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: TIMEOUT must be >= 2 and STARVE_MAX >= 1");
    end

    state_t            state_q, state_d;
    logic              own_d_q, own_d_d, wr_q, wr_d, err_q, err_d;
    logic              i_done_q, i_done_d, d_done_q, d_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, rdata;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              pick_d, grant, finish, force_i;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;
    assign force_i = (starve_q == STARVE_W'(STARVE_MAX)) && bus.i_req && bus.d_req;
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        own_d_d   = own_d_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        err_d     = err_q;
        finish    = 1'b0;
        rdata     = '0;
        pick_d    = bus.d_req && !force_i;
        // No grant while a done pulse is out, so a requester still holding req is not re-served.
        grant     = (state_q == IDLE) && !i_done_q && !d_done_q && (bus.d_req || bus.i_req);
        case (state_q)
            IDLE: if (grant) begin
                state_d = CMD;
                own_d_d = pick_d;
                wr_d    = pick_d && bus.d_wr;
                addr_d  = pick_d ? bus.d_addr : bus.i_addr;
                wdata_d = (pick_d && bus.d_wr) ? bus.d_wdata : '0;
            end
            CMD: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                finish  = bus.mem_valid || (wait_q == WAIT_W'(TIMEOUT - 1));
                err_d   = err_q || (finish && !bus.mem_valid);
                rdata   = (bus.mem_valid && !wr_q) ? bus.mem_rdata : '0;
                wait_d  = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
                state_d = finish ? IDLE : WAIT;
            end
            default: state_d = IDLE;
        endcase
        i_done_d  = finish && !own_d_q;
        d_done_d  = finish && own_d_q;
        i_rdata_d = i_done_d ? rdata : i_rdata_q;
        d_rdata_d = d_done_d ? rdata : d_rdata_q;
`ifdef ARB_STARVE_GUARD_EN
        starve_d  = !grant ? starve_q :
                    !pick_d ? '0 :
                    (bus.i_req && starve_q != STARVE_W'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_d_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= '0;
            err_q     <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_d_q   <= own_d_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else starve_q <= starve_d;
    end
`endif

    assign bus.mem_en    = (state_q == CMD);
    assign bus.mem_wr    = (state_q == CMD) && wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;
endmodule
